play_receiver_7e1: RTL
======================

Name: play_receiver_7e1

Overview:
- Receiving end of the play-report serial link.
- Deserializes 7E1 frames: start bit, 7 data bits LSB-first, even parity, 1 stop bit; line idles high.
- Parses the 4-character play message "<button>$<pos>#" and presents the decoded move, the 28-bit response word and error strobes.
- Sits on the host/checker side and feeds the expected-vs-response comparison logic.

Parameters:
- CLK_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be ≥ 4.
- CNT_W, 13, width of the bit-timing counter; must satisfy 2^CNT_W > CLK_PER_BIT.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- serial  in  1  asynchronous RX line; idles at 1.
- dado_ascii  out  7  last correctly received character (parity and stop OK).
- char_valido  out  1  1-cycle pulse when dado_ascii updates.
- botao_ascii  out  7  button character of the last valid message.
- pos  out  2  position of the last valid message (binary 0-3).
- resposta  out  28  {button, '$', pos digit, '#'} of the last valid message; button in bits 27:21, '#' in bits 6:0.
- jogada_valida  out  1  1-cycle pulse when a complete valid message is accepted.
- erro_paridade  out  1  1-cycle pulse on a parity error.
- erro_quadro  out  1  1-cycle pulse on a stop-bit error.
- erro_formato  out  1  1-cycle pulse on an unexpected character in the message.
- ocupado  out  1  1 while a frame is being received (any RX state other than IDLE).

Behaviour:
- Reset: every register and output is 0, except that the synchronizer flops are set to 1 (idle line). Both FSMs go to their initial states. Reset in the middle of a frame or a message discards all partial data.
- Input: `serial` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, ENTREGA.
  - IDLE: on a synchronized falling edge (1 to 0), load the timing counter and go to START.
  - START: after CLK_PER_BIT/2 cycles, sample the line. If it is 1, this is a false start: return to IDLE with no strobe. If 0, go to DATA.
  - DATA: sample every CLK_PER_BIT cycles, 7 samples, shifted in LSB-first.
  - PARITY: sample one bit. The frame passes parity when the XOR of the 7 data bits and the parity bit is 0.
  - STOP: sample one bit.
    - Stop = 0: pulse erro_quadro and discard the character. This has priority over a parity error.
    - Else, parity fail: pulse erro_paridade and discard the character.
    - Else: go to ENTREGA.
  - ENTREGA: one cycle. Update dado_ascii, pulse char_valido, hand the character to the parser, go to IDLE.
- A new start edge is accepted on the cycle after the FSM returns to IDLE. Back-to-back frames with no idle gap must be received.
- Parser FSM states: ESPERA_BOTAO, ESPERA_CIF, ESPERA_POS, ESPERA_HASH. It advances only on characters delivered by ENTREGA.
  - ESPERA_BOTAO: accepts only J (4A), Z (5A), Y (59), R (52), L (4C), A (41), B (42), C (43), D (44), all hex. Stores the character and goes to ESPERA_CIF. Any other character pulses erro_formato and stays.
  - ESPERA_CIF: '$' (24h) goes to ESPERA_POS.
  - ESPERA_POS: '0'..'3' (30h-33h). Stores the low 2 bits and goes to ESPERA_HASH.
  - ESPERA_HASH: '#' (23h) completes the message:
    - botao_ascii, pos and resposta register the new message;
    - jogada_valida pulses;
    - the parser returns to ESPERA_BOTAO.
  - Wrong character in ESPERA_CIF, ESPERA_POS or ESPERA_HASH: pulse erro_formato.
    - If the character is itself a valid button, store it and go to ESPERA_CIF (resync).
    - Otherwise go to ESPERA_BOTAO.
  - Discarded frames (parity or stop error) reset the parser to ESPERA_BOTAO. No erro_formato is raised for them.
- Latency: jogada_valida and char_valido assert 1 cycle after the stop-bit sample of the final character. Both are in the same cycle.
- botao_ascii, pos and resposta hold their values until the next valid message or reset.
- All error strobes are exactly 1 cycle wide. At most one error strobe fires per received character.

Test Plan:
1. CLK_PER_BIT=4: send frames 'A','$','2','#' with correct even parity.
   - jogada_valida pulses once, 1 cycle after the last stop sample.
   - botao_ascii=41h, pos=2, resposta={41h,24h,32h,23h}.
   - Four char_valido pulses, no error strobes.
2. Send 'C' with the parity bit inverted, then '$','1','#'.
   - erro_paridade pulses once.
   - The '$' pulses erro_formato.
   - No jogada_valida; outputs keep their previous values.
3. Send 'B','$','5','#'.
   - erro_formato on '5', parser back in ESPERA_BOTAO.
   - erro_formato again on '#'; no jogada_valida.
4. Send 'A','$','D','$','0','#'.
   - erro_formato on 'D' (resync to ESPERA_CIF).
   - Then jogada_valida with botao_ascii=44h, pos=0.
5. Line glitch low for 1 cycle, then idle.
   - No strobe, ocupado returns to 0.
   - The next valid message 'Y$3#' decodes with botao_ascii=59h, pos=3.
6. Assert reset=0 during DATA of the third character of 'R$1#'.
   - All outputs go to 0 immediately.
   - After release, a full 'L$0#' gives botao_ascii=4Ch, pos=0.

Source files
------------

// File: rtl/play_receiver_7e1_if.sv
// Signal bundle between the 7E1 play-report receiver and the comparison logic.
// The master side is the receiver; the slave side drives the line and consumes results.
interface play_receiver_7e1_if;
    logic        serial;
    logic [6:0]  dado_ascii;
    logic        char_valido;
    logic [6:0]  botao_ascii;
    logic [1:0]  pos;
    logic [27:0] resposta;
    logic        jogada_valida;
    logic        erro_paridade;
    logic        erro_quadro;
    logic        erro_formato;
    logic        ocupado;

    modport master (
        input  serial,
        output dado_ascii, char_valido, botao_ascii, pos, resposta,
               jogada_valida, erro_paridade, erro_quadro, erro_formato, ocupado
    );

    modport slave (
        output serial,
        input  dado_ascii, char_valido, botao_ascii, pos, resposta,
               jogada_valida, erro_paridade, erro_quadro, erro_formato, ocupado
    );
endinterface

// File: rtl/play_receiver_7e1.sv
// 7E1 UART receiver plus parser for the 4-character play message "<button>$<pos>#".
// Presents the decoded move, the 28-bit response word and single-cycle error strobes.
module play_receiver_7e1 #(
    parameter int CLK_PER_BIT = 5208,
    parameter int CNT_W       = 13
) (
    input  logic                 clock,
    input  logic                 reset,
    play_receiver_7e1_if.master  rx
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [6:0]       CH_CIF    = 7'h24;
    localparam logic [6:0]       CH_HASH   = 7'h23;
    localparam logic [4:0]       DIGIT_HI  = 5'b01100;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, ENTREGA
    } rx_state_t;

    typedef enum logic [1:0] {
        ESPERA_BOTAO, ESPERA_CIF, ESPERA_POS, ESPERA_HASH
    } parse_state_t;

    rx_state_t    rx_state;
    parse_state_t p_state;

    logic             sync_1, sync_2, line_prev;
    logic [CNT_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [6:0]       shift;
    logic             par_bit;
    logic [6:0]       botao_pend;
    logic [1:0]       pos_pend;

    logic timer_done, parity_fail, frame_drop, char_take, btn_ok, char_ok;

    function automatic logic is_button(input logic [6:0] c);
        case (c)
            7'h4A, 7'h5A, 7'h59, 7'h52, 7'h4C,
            7'h41, 7'h42, 7'h43, 7'h44: is_button = 1'b1;
            default:                    is_button = 1'b0;
        endcase
    endfunction

    assign timer_done  = (timer == '0);
    assign parity_fail = ^{shift, par_bit};
    // A frame that fails its stop or parity check is dropped and also restarts the parser.
    assign frame_drop  = (rx_state == STOP) && timer_done && (!sync_2 || parity_fail);
    assign char_take   = (rx_state == ENTREGA);
    assign btn_ok      = is_button(shift);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        char_ok = 1'b0;
        unique case (p_state)
            ESPERA_BOTAO: char_ok = btn_ok;
            ESPERA_CIF:   char_ok = (shift == CH_CIF);
            ESPERA_POS:   char_ok = (shift[6:2] == DIGIT_HI);
            ESPERA_HASH:  char_ok = (shift == CH_HASH);
            default:      char_ok = 1'b0;
        endcase
    end

    // Receive FSM: synchronizer, bit timing, deserialization and frame checks.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: synchronizer flops reset to 1 so reset release never looks like a start edge.
            sync_1           <= 1'b1;
            sync_2           <= 1'b1;
            line_prev        <= 1'b1;
            rx_state         <= IDLE;
            timer            <= '0;
            bit_idx          <= '0;
            shift            <= '0;
            par_bit          <= 1'b0;
            rx.dado_ascii    <= '0;
            rx.char_valido   <= 1'b0;
            rx.erro_paridade <= 1'b0;
            rx.erro_quadro   <= 1'b0;
            rx.ocupado       <= 1'b0;
        end else begin
            sync_1           <= rx.serial;
            sync_2           <= sync_1;
            line_prev        <= sync_2;
            rx.char_valido   <= 1'b0;
            rx.erro_paridade <= 1'b0;
            rx.erro_quadro   <= 1'b0;

            unique case (rx_state)
                IDLE: begin
                    if (line_prev && !sync_2) begin
                        timer      <= HALF_LOAD;
                        rx_state   <= START;
                        rx.ocupado <= 1'b1;
                    end
                end

                START: begin
                    if (!timer_done) begin
                        timer <= timer - CNT_ONE;
                    end else if (sync_2) begin
                        rx_state   <= IDLE;
                        rx.ocupado <= 1'b0;
                    end else begin
                        timer    <= BIT_LOAD;
                        bit_idx  <= '0;
                        rx_state <= DATA;
                    end
                end

                DATA: begin
                    if (!timer_done) begin
                        timer <= timer - CNT_ONE;
                    end else begin
                        shift <= {sync_2, shift[6:1]};
                        timer <= BIT_LOAD;
                        if (bit_idx == 3'd6) rx_state <= PARITY;
                        else                 bit_idx  <= bit_idx + 3'd1;
                    end
                end

                PARITY: begin
                    if (!timer_done) begin
                        timer <= timer - CNT_ONE;
                    end else begin
                        par_bit  <= sync_2;
                        timer    <= BIT_LOAD;
                        rx_state <= STOP;
                    end
                end

                STOP: begin
                    if (!timer_done) begin
                        timer <= timer - CNT_ONE;
                    end else if (!sync_2) begin
                        rx.erro_quadro <= 1'b1;
                        rx_state       <= IDLE;
                        rx.ocupado     <= 1'b0;
                    end else if (parity_fail) begin
                        rx.erro_paridade <= 1'b1;
                        rx_state         <= IDLE;
                        rx.ocupado       <= 1'b0;
                    end else begin
                        rx_state <= ENTREGA;
                    end
                end

                ENTREGA: begin
                    rx.dado_ascii  <= shift;
                    rx.char_valido <= 1'b1;
                    rx_state       <= IDLE;
                    rx.ocupado     <= 1'b0;
                end

                default: begin
                    rx_state   <= IDLE;
                    rx.ocupado <= 1'b0;
                end
            endcase
        end
    end

    // Message parser: advances only on delivered characters; a bad character that is
    // itself a button restarts a message instead of being lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_state          <= ESPERA_BOTAO;
            botao_pend       <= '0;
            pos_pend         <= '0;
            rx.botao_ascii   <= '0;
            rx.pos           <= '0;
            rx.resposta      <= '0;
            rx.jogada_valida <= 1'b0;
            rx.erro_formato  <= 1'b0;
        end else begin
            rx.jogada_valida <= 1'b0;
            rx.erro_formato  <= 1'b0;

            if (frame_drop) begin
                p_state <= ESPERA_BOTAO;
            end else if (char_take) begin
                if (char_ok) begin
                    unique case (p_state)
                        ESPERA_BOTAO: begin
                            botao_pend <= shift;
                            p_state    <= ESPERA_CIF;
                        end
                        ESPERA_CIF: p_state <= ESPERA_POS;
                        ESPERA_POS: begin
                            pos_pend <= shift[1:0];
                            p_state  <= ESPERA_HASH;
                        end
                        ESPERA_HASH: begin
                            rx.botao_ascii   <= botao_pend;
                            rx.pos           <= pos_pend;
                            rx.resposta      <= {botao_pend, CH_CIF, DIGIT_HI, pos_pend, CH_HASH};
                            rx.jogada_valida <= 1'b1;
                            p_state          <= ESPERA_BOTAO;
                        end
                        default: p_state <= ESPERA_BOTAO;
                    endcase
                end else begin
                    rx.erro_formato <= 1'b1;
                    if (btn_ok) begin
                        botao_pend <= shift;
                        p_state    <= ESPERA_CIF;
                    end else begin
                        p_state <= ESPERA_BOTAO;
                    end
                end
            end
        end
    end

endmodule
